// File: rtl/instruction_fetch_pkg.sv
// Shared CPU constants for the fetch stage: FSM encoding, bubble word, reset PC
// and the major-opcode field values.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [4:0]  OPC_NOP                 = 5'b00001;
   localparam logic [15:0] DEFAULT_NOP_INSTRUCTION = {OPC_NOP, 11'd0};
   localparam logic [15:0] DEFAULT_RESET_PC        = 16'h0000;

   // 16-bit wrap from FFFF to 0000 falls out of the truncation.
   function automatic logic [15:0] pc_increment(input logic [15:0] pc);
      return pc + 16'd1;
   endfunction

endpackage

// File: rtl/instruction_fetch_hold_buffer.sv
// One-entry holding register for a word granted while the decoder is stalled.
module fetch_hold_buffer (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [15:0] load_data,
   output logic [15:0] data,
   output logic        valid
);

   logic [15:0] data_reg;
   logic        valid_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_reg  <= 16'd0;
         valid_reg <= 1'b0;
      end else if (clear) begin
         data_reg  <= 16'd0;
         valid_reg <= 1'b0;
      end else if (load) begin
         data_reg  <= load_data;
         valid_reg <= 1'b1;
      end
   end

   assign data  = data_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, memory request FSM and stall holding register.
// Optional macro INSTRUCTION_FETCH_DELAY_SLOT_EN issues the word alongside a redirect.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC        = DEFAULT_RESET_PC,
   parameter logic [15:0] NOP_INSTRUCTION = DEFAULT_NOP_INSTRUCTION
) (
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] instAddress,
   output logic        instRequest,
   input  logic [15:0] instData,
   input  logic        instReady,
   input  logic        stall,
   input  logic        redirectValid,
   input  logic [15:0] redirectTarget,
   output logic [15:0] currentInstruction,
   output logic [15:0] currentPC,
   output logic        instructionValid
);

   fetch_state_t state_reg, state_next;
   logic [15:0]  pc_reg, pc_next;
   logic [15:0]  inst_reg, inst_next;
   logic [15:0]  cpc_reg, cpc_next;
   logic         valid_reg, valid_next;
   logic         hold_load, hold_clear, hold_valid;
   logic [15:0]  hold_data;

   fetch_hold_buffer u_hold (
      .clock     (clock),
      .reset     (reset),
      .load      (hold_load),
      .clear     (hold_clear),
      .load_data (instData),
      .data      (hold_data),
      .valid     (hold_valid)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= FETCH;
         pc_reg    <= RESET_PC;
         inst_reg  <= NOP_INSTRUCTION;
         cpc_reg   <= RESET_PC;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         inst_reg  <= inst_next;
         cpc_reg   <= cpc_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      inst_next  = inst_reg;
      cpc_next   = cpc_reg;
      valid_next = valid_reg;
      hold_load  = 1'b0;
      hold_clear = 1'b0;

      if (redirectValid) begin
         state_next = FETCH;
         pc_next    = redirectTarget;
         hold_clear = 1'b1;
         inst_next  = NOP_INSTRUCTION;
         valid_next = 1'b0;
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
         // The delay-slot word is whatever would have issued next: the held
         // word when holding, otherwise the word granted this cycle.
         if (state_reg == HOLD) begin
            inst_next  = hold_data;
            cpc_next   = pc_reg;
            valid_next = hold_valid;
         end else if (instReady) begin
            inst_next  = instData;
            cpc_next   = pc_increment(pc_reg);
            valid_next = 1'b1;
         end
`endif
      end else if (state_reg == HOLD) begin
         // pc already points past the held word, so it is the held word's PC+1.
         if (!stall) begin
            inst_next  = hold_data;
            cpc_next   = pc_reg;
            valid_next = hold_valid;
            hold_clear = 1'b1;
            state_next = FETCH;
         end
      end else if (instReady) begin
         pc_next = pc_increment(pc_reg);
         if (stall) begin
            hold_load  = 1'b1;
            state_next = HOLD;
         end else begin
            inst_next  = instData;
            cpc_next   = pc_increment(pc_reg);
            valid_next = 1'b1;
            state_next = FETCH;
         end
      end else begin
         state_next = WAIT;
         if (!stall) begin
            inst_next  = NOP_INSTRUCTION;
            valid_next = 1'b0;
         end
      end
   end

   assign instAddress        = pc_reg;
   assign instRequest        = reset && (state_reg != HOLD);
   assign currentInstruction = inst_reg;
   assign currentPC          = cpc_reg;
   assign instructionValid   = valid_reg;

endmodule
